// File: rtl/rv32imc_1p_wb_ctrl.sv
// Write-back controller for the single register-file write port.
// Merges ALU, load and MUL/DIV results into one registered write per cycle
// and keeps a scoreboard of destinations still waiting on LD/MD results,
// raising a decode stall on RAW/WAW hazards against them.
module rv32imc_1p_wb_ctrl #(
  parameter int XLEN       = 32,
  parameter int AW         = 5,
  parameter int NREG       = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  // single-cycle ALU result (never back-pressured)
  input  logic            alu_wr,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_dat,
  // load return
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [AW-1:0]   ld_rd,
  input  logic [XLEN-1:0] ld_dat,
  // multi-cycle MUL/DIV result
  input  logic            md_valid,
  output logic            md_ready,
  input  logic [AW-1:0]   md_rd,
  input  logic [XLEN-1:0] md_dat,
  // long-latency issue (marks destination pending)
  input  logic            iss_long,
  input  logic [AW-1:0]   iss_rd,
  // decode hazard query
  input  logic [AW-1:0]   dec_rs1,
  input  logic [AW-1:0]   dec_rs2,
  input  logic [AW-1:0]   dec_rd,
  input  logic            dec_wr,
  output logic            stall,
  // register-file write port
  output logic            c_rf_write,
  output logic [AW-1:0]   rd_addr,
  output logic [XLEN-1:0] rd_dati
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0]   starve_q, starve_d;
  logic            c_rf_write_q, c_rf_write_d;
  logic            long_wr_q, long_wr_d;
  logic [AW-1:0]   rd_addr_q, rd_addr_d;
  logic [XLEN-1:0] rd_dati_q, rd_dati_d;
  logic [NREG-1:0] pending_q, pending_d;

  logic            starve_sat;
  logic            alu_go, ld_go, md_go, any_go;
  logic [AW-1:0]   win_rd;
  logic [XLEN-1:0] win_dat;
  logic            clr_en;

  // MD has waited long enough to pre-empt LD (it still yields to ALU)
  assign starve_sat = (starve_q == CW'(STARVE_MAX));

  // Grant: ALU > LD > MD, except a starved MD beats LD. Each ready only
  // looks at the other sources, never at its own rd/dat.
  always_comb begin
    ld_ready = !alu_wr && !(md_valid && starve_sat);
    md_ready = !alu_wr && (!ld_valid || starve_sat);
  end

  assign alu_go = alu_wr;
  assign ld_go  = ld_valid && ld_ready;
  assign md_go  = md_valid && md_ready;
  assign any_go = alu_go || ld_go || md_go;

  // Select the winning source's destination and data
  always_comb begin
    win_rd  = '0;
    win_dat = '0;
    if (alu_go) begin
      win_rd  = alu_rd;
      win_dat = alu_dat;
    end else if (ld_go) begin
      win_rd  = ld_rd;
      win_dat = ld_dat;
    end else if (md_go) begin
      win_rd  = md_rd;
      win_dat = md_dat;
    end
  end

  // Starve counter: counts MD hold-offs, saturates, clears on accept or idle
  always_comb begin
    starve_d = '0;
    if (md_valid && !md_ready) begin
      starve_d = starve_sat ? starve_q : starve_q + CW'(1);
    end
  end

  // Next write-port state; x0 writes complete the handshake but are dropped
  always_comb begin
    c_rf_write_d = any_go && (win_rd != '0);
    long_wr_d    = c_rf_write_d && !alu_go;
    rd_addr_d    = rd_addr_q;
    rd_dati_d    = rd_dati_q;
    if (c_rf_write_d) begin
      rd_addr_d = win_rd;
      rd_dati_d = win_dat;
    end
  end

  // A committed LD/MD write retires its scoreboard entry
  assign clr_en = c_rf_write_q && long_wr_q;

  // Scoreboard next state: clear on LD/MD commit, set on issue (set wins)
  always_comb begin
    pending_d = pending_q;
    for (int i = 1; i < NREG; i++) begin
      if (clr_en && (rd_addr_q == AW'(i))) pending_d[i] = 1'b0;
      if (iss_long && (iss_rd == AW'(i)))  pending_d[i] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  // State registers; reset drops any in-flight write and the scoreboard
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_q     <= '0;
      c_rf_write_q <= 1'b0;
      long_wr_q    <= 1'b0;
      rd_addr_q    <= '0;
      rd_dati_q    <= '0;
      pending_q    <= '0;
    end else begin
      starve_q     <= starve_d;
      c_rf_write_q <= c_rf_write_d;
      long_wr_q    <= long_wr_d;
      rd_addr_q    <= rd_addr_d;
      rd_dati_q    <= rd_dati_d;
      pending_q    <= pending_d;
    end
  end

  // Decode hazard: RAW on either source, WAW on the destination
  always_comb begin
    stall = pending_q[dec_rs1] | pending_q[dec_rs2] | (dec_wr & pending_q[dec_rd]);
  end

  assign c_rf_write = c_rf_write_q;
  assign rd_addr    = rd_addr_q;
  assign rd_dati    = rd_dati_q;

  // Decode must hold a long op whose rd is still pending (unless it retires this edge)
  a_no_waw_issue : assert property (@(posedge clk) disable iff (!reset_n)
    (iss_long && (iss_rd != '0)) |->
      (!pending_q[iss_rd] || (clr_en && (rd_addr_q == iss_rd))));

  // Two long results can never target the same register at once
  a_no_ld_md_same_rd : assert property (@(posedge clk) disable iff (!reset_n)
    (ld_valid && md_valid && (ld_rd != '0)) |-> (ld_rd != md_rd));

endmodule

// File: tb/tb_rv32imc_1p_wb_ctrl.sv
// Directed bench for the write-back controller: hand-computed expectations.
module tb_rv32imc_1p_wb_ctrl;

  logic        clk;
  logic        reset_n;
  logic        alu_wr;
  logic [4:0]  alu_rd;
  logic [31:0] alu_dat;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_dat;
  logic        md_valid;
  logic        md_ready;
  logic [4:0]  md_rd;
  logic [31:0] md_dat;
  logic        iss_long;
  logic [4:0]  iss_rd;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic [4:0]  dec_rd;
  logic        dec_wr;
  logic        stall;
  logic        c_rf_write;
  logic [4:0]  rd_addr;
  logic [31:0] rd_dati;

  int n_tests = 0;
  int n_fail  = 0;

  rv32imc_1p_wb_ctrl #(
    .XLEN(32), .AW(5), .NREG(32), .STARVE_MAX(4)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .alu_wr(alu_wr), .alu_rd(alu_rd), .alu_dat(alu_dat),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_dat(ld_dat),
    .md_valid(md_valid), .md_ready(md_ready), .md_rd(md_rd), .md_dat(md_dat),
    .iss_long(iss_long), .iss_rd(iss_rd),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd), .dec_wr(dec_wr),
    .stall(stall),
    .c_rf_write(c_rf_write), .rd_addr(rd_addr), .rd_dati(rd_dati)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: 0x%08h", tag, got);
    end
  endtask

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    alu_wr = 0; alu_rd = 0; alu_dat = 0;
    ld_valid = 0; ld_rd = 0; ld_dat = 0;
    md_valid = 0; md_rd = 0; md_dat = 0;
    iss_long = 0; iss_rd = 0;
    dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0; dec_wr = 0;

    // ---- reset state ----
    tick(); tick();
    check_val("rst_c_rf_write", 32'(c_rf_write), 32'd0);
    check_val("rst_rd_addr", 32'(rd_addr), 32'd0);
    check_val("rst_rd_dati", rd_dati, 32'd0);
    check_val("rst_stall", 32'(stall), 32'd0);
    check_val("rst_ld_ready", 32'(ld_ready), 32'd1);
    check_val("rst_md_ready", 32'(md_ready), 32'd1);
    reset_n = 1'b1;
    tick();

    // ---- 1: ALU only ----
    alu_wr = 1; alu_rd = 5; alu_dat = 32'hDEADBEEF;
    #1;
    check_val("t1_ld_ready", 32'(ld_ready), 32'd0);
    check_val("t1_md_ready", 32'(md_ready), 32'd0);
    tick();
    alu_wr = 0;
    check_val("t1_wr", 32'(c_rf_write), 32'd1);
    check_val("t1_addr", 32'(rd_addr), 32'd5);
    check_val("t1_dati", rd_dati, 32'hDEADBEEF);
    check_val("t1_stall", 32'(stall), 32'd0);
    tick();
    check_val("t1_idle_wr", 32'(c_rf_write), 32'd0);
    check_val("t1_idle_hold", 32'(rd_addr), 32'd5);

    // ---- 2: RAW stall on pending load ----
    iss_long = 1; iss_rd = 7; dec_rs1 = 7;
    #1;
    check_val("t2_stall_pre", 32'(stall), 32'd0);
    tick();
    iss_long = 0;
    check_val("t2_stall_set", 32'(stall), 32'd1);
    tick();
    check_val("t2_stall_hold", 32'(stall), 32'd1);
    ld_valid = 1; ld_rd = 7; ld_dat = 32'h0000_1234;
    #1;
    check_val("t2_ld_ready", 32'(ld_ready), 32'd1);
    tick();
    ld_valid = 0;
    check_val("t2_wr", 32'(c_rf_write), 32'd1);
    check_val("t2_addr", 32'(rd_addr), 32'd7);
    check_val("t2_dati", rd_dati, 32'h0000_1234);
    check_val("t2_stall_commit", 32'(stall), 32'd1);
    tick();
    check_val("t2_stall_clr", 32'(stall), 32'd0);
    dec_rs1 = 0;

    // ---- 2b: ALU write does not clear pending; WAW via dec_wr ----
    iss_long = 1; iss_rd = 9;
    tick();
    iss_long = 0;
    alu_wr = 1; alu_rd = 9; alu_dat = 32'h5;
    tick();
    alu_wr = 0;
    check_val("t2b_alu_wr", 32'(c_rf_write), 32'd1);
    tick();
    dec_rd = 9; dec_wr = 0;
    #1;
    check_val("t2b_no_wr_nostall", 32'(stall), 32'd0);
    dec_wr = 1;
    #1;
    check_val("t2b_waw_stall", 32'(stall), 32'd1);
    md_valid = 1; md_rd = 9; md_dat = 32'h99;
    #1;
    check_val("t2b_md_ready", 32'(md_ready), 32'd1);
    tick();
    md_valid = 0;
    check_val("t2b_md_addr", 32'(rd_addr), 32'd9);
    check_val("t2b_md_dati", rd_dati, 32'h99);
    tick();
    check_val("t2b_waw_clr", 32'(stall), 32'd0);
    dec_wr = 0; dec_rd = 0;

    // ---- 3: all three sources at once ----
    alu_wr = 1; alu_rd = 1; alu_dat = 32'hA;
    ld_valid = 1; ld_rd = 2; ld_dat = 32'hB;
    md_valid = 1; md_rd = 3; md_dat = 32'hC;
    #1;
    check_val("t3_ld_ready0", 32'(ld_ready), 32'd0);
    check_val("t3_md_ready0", 32'(md_ready), 32'd0);
    tick();
    alu_wr = 0;
    check_val("t3_w1_addr", 32'(rd_addr), 32'd1);
    check_val("t3_w1_dati", rd_dati, 32'hA);
    #1;
    check_val("t3_ld_ready1", 32'(ld_ready), 32'd1);
    check_val("t3_md_ready1", 32'(md_ready), 32'd0);
    tick();
    ld_valid = 0;
    check_val("t3_w2_addr", 32'(rd_addr), 32'd2);
    check_val("t3_w2_dati", rd_dati, 32'hB);
    #1;
    check_val("t3_md_ready2", 32'(md_ready), 32'd1);
    tick();
    md_valid = 0;
    check_val("t3_w3_wr", 32'(c_rf_write), 32'd1);
    check_val("t3_w3_addr", 32'(rd_addr), 32'd3);
    check_val("t3_w3_dati", rd_dati, 32'hC);

    // ---- 4: MD starvation relief on the 5th cycle ----
    md_valid = 1; md_rd = 4; md_dat = 32'h44;
    for (int i = 1; i <= 6; i++) begin
      if (i == 6) begin
        md_rd = 6; md_dat = 32'h66;
      end
      ld_valid = 1; ld_rd = 5'(10 + i); ld_dat = 32'h100 + 32'(i);
      #1;
      check_val($sformatf("t4_md_ready_c%0d", i), 32'(md_ready), (i == 5) ? 32'd1 : 32'd0);
      check_val($sformatf("t4_ld_ready_c%0d", i), 32'(ld_ready), (i == 5) ? 32'd0 : 32'd1);
      tick();
      check_val($sformatf("t4_addr_c%0d", i), 32'(rd_addr), (i == 5) ? 32'd4 : 32'(10 + i));
    end
    ld_valid = 0; md_valid = 0;
    tick();

    // ---- 5: MD to x0 ----
    md_valid = 1; md_rd = 0; md_dat = 32'hFF;
    #1;
    check_val("t5_md_ready", 32'(md_ready), 32'd1);
    tick();
    md_valid = 0;
    check_val("t5_wr", 32'(c_rf_write), 32'd0);
    check_val("t5_addr_hold", 32'(rd_addr), 32'd16);

    // ---- 6: reset during a write with pending[3] ----
    iss_long = 1; iss_rd = 3;
    tick();
    iss_long = 0;
    alu_wr = 1; alu_rd = 12; alu_dat = 32'h77;
    tick();
    alu_wr = 0;
    dec_rs1 = 3;
    #1;
    check_val("t6_pre_wr", 32'(c_rf_write), 32'd1);
    check_val("t6_pre_stall", 32'(stall), 32'd1);
    reset_n = 0;
    #1;
    check_val("t6_rst_wr", 32'(c_rf_write), 32'd0);
    check_val("t6_rst_addr", 32'(rd_addr), 32'd0);
    check_val("t6_rst_dati", rd_dati, 32'd0);
    check_val("t6_rst_stall", 32'(stall), 32'd0);
    tick();
    reset_n = 1;
    tick();
    check_val("t6_post_wr", 32'(c_rf_write), 32'd0);
    check_val("t6_post_stall", 32'(stall), 32'd0);
    dec_rs1 = 0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
